// File: rtl/fp_pkg.sv
// Shared binary32 constants, FSM state encoding and unpack helper for the sequential FP adder.
package fp_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t StIdle  = 3'd0;
    localparam fsm_state_t StAlign = 3'd1;
    localparam fsm_state_t StAdd   = 3'd2;
    localparam fsm_state_t StNorm  = 3'd3;
    localparam fsm_state_t StRound = 3'd4;
    localparam fsm_state_t StHold  = 3'd5;

    // Mantissa with hidden bit restored; denormals collapse to zero.
    function automatic logic [MAN_W:0] unpack_man(input logic [31:0] x);
        if (x[MAN_W +: EXP_W] == '0) begin
            return '0;
        end
        return {1'b1, x[MAN_W-1:0]};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// 27-bit combinational leading-zero counter; all-zero input reported separately.
module fp_lzc (
    input  logic [26:0] din,
    output logic [4:0]  count,
    output logic        all_zero
);

    always_comb begin
        count = 5'd27;
        // Ascending scan: the highest set bit writes last and wins.
        for (int i = 0; i < 27; i++) begin
            if (din[i]) begin
                count = 5'(26 - i);
            end
        end
    end

    assign all_zero = (din == '0);

endmodule

// File: rtl/fp_add_seq.sv
// Sequential binary32 adder: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> HOLD, one op in flight.
module fp_add_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_ovf
);

    fsm_state_t state_q, state_d;

    logic [31:0]       a_q, b_q;
    logic              sign_a_q, sign_b_q;
    logic [EXP_W-1:0]  exp_a_q, exp_b_q;
    logic [MAN_W:0]    man_a_q, man_b_q;

    logic [26:0]       big_q, small_q;
    logic              eff_sub_q, sign_q;
    logic signed [9:0] exp_q;
    logic              spec_q, spec_inv_q;
    logic [31:0]       spec_res_q;
    logic [27:0]       sum_q;
    logic [26:0]       norm_q;
    logic              zero_q;
    logic [31:0]       result_q;
    logic              flag_invalid_q, flag_ovf_q;

    // ALIGN stage
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [EXP_W-1:0] exp_big, exp_small, exp_diff;
    logic [MAN_W:0]   man_big, man_small;
    logic [26:0]      small_ext, small_shift;
    logic             al_spec, al_inv;
    logic [31:0]      al_res;

    assign a_zero = (exp_a_q == '0);
    assign b_zero = (exp_b_q == '0);
    assign a_inf  = (exp_a_q == EXP_W'(EXP_MAX)) && (a_q[MAN_W-1:0] == '0);
    assign b_inf  = (exp_b_q == EXP_W'(EXP_MAX)) && (b_q[MAN_W-1:0] == '0);
    assign a_nan  = (exp_a_q == EXP_W'(EXP_MAX)) && (a_q[MAN_W-1:0] != '0);
    assign b_nan  = (exp_b_q == EXP_W'(EXP_MAX)) && (b_q[MAN_W-1:0] != '0);

    always_comb begin
        a_big     = {exp_a_q, man_a_q} >= {exp_b_q, man_b_q};
        exp_big   = a_big ? exp_a_q : exp_b_q;
        exp_small = a_big ? exp_b_q : exp_a_q;
        man_big   = a_big ? man_a_q : man_b_q;
        man_small = a_big ? man_b_q : man_a_q;
        exp_diff  = exp_big - exp_small;
        small_ext = {man_small, 3'b000};
        if (exp_diff >= 8'd27) begin
            small_shift = {26'd0, |small_ext};
        end else begin
            small_shift = (small_ext >> exp_diff)
                        | {26'd0, |(small_ext & ~(27'h7FF_FFFF << exp_diff))};
        end
    end

    always_comb begin
        al_spec = 1'b1;
        al_inv  = 1'b0;
        al_res  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sign_a_q != sign_b_q))) begin
            al_res = QNAN;
            al_inv = 1'b1;
        end else if (a_inf) begin
            al_res = a_q;
        end else if (b_inf) begin
            al_res = b_q;
        end else if (a_zero && b_zero) begin
            al_res = {sign_a_q & sign_b_q, 31'd0};
        end else begin
            al_spec = 1'b0;
        end
    end

    // NORM stage
    logic [4:0]        lz;
    logic              lz_zero;
    logic [26:0]       norm_m;
    logic signed [9:0] norm_exp;
    logic              norm_zero;

    fp_lzc u_lzc (
        .din      (sum_q[26:0]),
        .count    (lz),
        .all_zero (lz_zero)
    );

    always_comb begin
        norm_m    = sum_q[26:0];
        norm_exp  = exp_q;
        norm_zero = 1'b0;
        if (sum_q[27]) begin
            norm_m   = {sum_q[27:2], sum_q[1] | sum_q[0]};
            norm_exp = exp_q + 10'sd1;
        end else begin
            norm_m    = sum_q[26:0] << lz;
            norm_exp  = exp_q - $signed({5'd0, lz});
            norm_zero = lz_zero;
        end
    end

    // ROUND stage
    logic              rnd_up;
    logic [24:0]       man_rnd;
    logic [MAN_W-1:0]  rnd_frac;
    logic signed [9:0] rnd_exp;
    logic [31:0]       fin_res;
    logic              fin_inv, fin_ovf;

    always_comb begin
        rnd_up   = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        man_rnd  = {1'b0, norm_q[26:3]} + {24'd0, rnd_up};
        rnd_frac = man_rnd[MAN_W-1:0];
        rnd_exp  = exp_q;
        if (man_rnd[24]) begin
            rnd_frac = man_rnd[23:1];
            rnd_exp  = exp_q + 10'sd1;
        end
        fin_res = '0;
        fin_inv = 1'b0;
        fin_ovf = 1'b0;
        if (spec_q) begin
            fin_res = spec_res_q;
            fin_inv = spec_inv_q;
        end else if (zero_q) begin
            fin_res = '0;
        end else if (rnd_exp >= 10'sd255) begin
            fin_res = {sign_q, 8'hFF, 23'd0};
            fin_ovf = 1'b1;
        end else if (rnd_exp <= 10'sd0) begin
            fin_res = {sign_q, 31'd0};
        end else begin
            fin_res = {sign_q, rnd_exp[7:0], rnd_frac};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            a_q            <= '0;
            b_q            <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            exp_a_q        <= '0;
            exp_b_q        <= '0;
            man_a_q        <= '0;
            man_b_q        <= '0;
            big_q          <= '0;
            small_q        <= '0;
            eff_sub_q      <= 1'b0;
            sign_q         <= 1'b0;
            exp_q          <= '0;
            spec_q         <= 1'b0;
            spec_inv_q     <= 1'b0;
            spec_res_q     <= '0;
            sum_q          <= '0;
            norm_q         <= '0;
            zero_q         <= 1'b0;
            result_q       <= '0;
            flag_invalid_q <= 1'b0;
            flag_ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        sign_a_q <= a[31];
                        sign_b_q <= b[31];
                        exp_a_q  <= a[MAN_W +: EXP_W];
                        exp_b_q  <= b[MAN_W +: EXP_W];
                        man_a_q  <= unpack_man(a);
                        man_b_q  <= unpack_man(b);
                    end
                end
                StAlign: begin
                    big_q      <= {man_big, 3'b000};
                    small_q    <= small_shift;
                    eff_sub_q  <= sign_a_q ^ sign_b_q;
                    sign_q     <= a_big ? sign_a_q : sign_b_q;
                    exp_q      <= $signed({2'b00, exp_big});
                    spec_q     <= al_spec;
                    spec_inv_q <= al_inv;
                    spec_res_q <= al_res;
                end
                StAdd: begin
                    sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                       : ({1'b0, big_q} + {1'b0, small_q});
                end
                StNorm: begin
                    norm_q <= norm_m;
                    exp_q  <= norm_exp;
                    zero_q <= norm_zero;
                end
                StRound: begin
                    result_q       <= fin_res;
                    flag_invalid_q <= fin_inv;
                    flag_ovf_q     <= fin_ovf;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StHold);
    assign result       = result_q;
    assign flag_invalid = flag_invalid_q;
    assign flag_ovf     = flag_ovf_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed vectors, handshake/reset sequences, random vs exact model.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_ovf;

    int checks   = 0;
    int failures = 0;

    fp_add_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_invalid (flag_invalid),
        .flag_ovf     (flag_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        inv;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Exact-integer reference: sum at a common scale, then one round-to-nearest-even.
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic inv, output logic ovf);
        int ex, ey, emin, p, k, e_res;
        logic sx, sy, xnan, ynan, xinf, yinf, xzero, yzero, s;
        logic [127:0] ux, uy, mag, man, rem, half;
        logic signed [127:0] total;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sx = x[31];
        sy = y[31];
        xnan = (ex == 255) && (x[22:0] != 0);
        ynan = (ey == 255) && (y[22:0] != 0);
        xinf = (ex == 255) && (x[22:0] == 0);
        yinf = (ey == 255) && (y[22:0] == 0);
        xzero = (ex == 0);
        yzero = (ey == 0);
        inv = 1'b0;
        ovf = 1'b0;
        r = 32'h0;
        if (xnan || ynan || (xinf && yinf && sx != sy)) begin
            r = 32'h7FC00000;
            inv = 1'b1;
            return;
        end
        if (xinf) begin r = x; return; end
        if (yinf) begin r = y; return; end
        if (xzero && yzero) begin r = {sx & sy, 31'd0}; return; end
        if (xzero) begin r = y; return; end
        if (yzero) begin r = x; return; end
        // Beyond this gap the smaller addend is far below a quarter ulp of the larger.
        if (ex - ey > 60) begin r = x; return; end
        if (ey - ex > 60) begin r = y; return; end
        emin = (ex < ey) ? ex : ey;
        ux = 128'({1'b1, x[22:0]}) << (ex - emin);
        uy = 128'({1'b1, y[22:0]}) << (ey - emin);
        total = $signed((sx ? -ux : ux) + (sy ? -uy : uy));
        if (total == 0) begin r = 32'h0; return; end
        s = total[127];
        mag = s ? 128'(-total) : 128'(total);
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e_res = emin + p - 23;
        if (p > 23) begin
            k = p - 23;
            man = mag >> k;
            rem = mag & ((128'd1 << k) - 128'd1);
            half = 128'd1 << (k - 1);
            if (rem > half || (rem == half && man[0])) man = man + 128'd1;
            if (man == (128'd1 << 24)) begin
                man = man >> 1;
                e_res++;
            end
        end else begin
            man = mag << (23 - p);
        end
        if (e_res >= 255) begin
            r = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (e_res <= 0) begin
            r = {s, 31'd0};
        end else begin
            r = {s, 8'(e_res), man[22:0]};
        end
    endfunction

    function automatic logic [31:0] pick_special();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return 32'hFF812345;
            6: return 32'h00012345;
            default: return 32'h807FFFFF;
        endcase
    endfunction

    function automatic logic [31:0] gen_a();
        if ($urandom_range(0, 9) == 0) return pick_special();
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] gen_b(input logic [31:0] x);
        int sel;
        int e;
        sel = $urandom_range(0, 99);
        if (sel < 55) begin
            e = int'(x[30:23]) + int'($urandom_range(0, 8)) - 4;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            return {1'($urandom), 8'(e), 23'($urandom)};
        end else if (sel < 70) begin
            return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        end else if (sel < 80) begin
            return {~x[31], x[30:23], x[22:0] ^ 23'($urandom_range(0, 3))};
        end else if (sel < 90) begin
            return pick_special();
        end
        return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
    endfunction

    // One full transaction; returns captured outputs and cycles from accept edge to out_valid.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input int hold,
                         output logic [31:0] r, output logic fi, output logic fo,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        fi = flag_invalid;
        fo = flag_ovf;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t        vecs[14];
    logic [31:0] r, r_exp;
    logic        fi, fo, fi_exp, fo_exp;
    int          lat;
    int          seen;

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0};
        vecs[3]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0, 1'b1};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
        vecs[11] = '{32'h00800001, 32'h80800000, 32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0};
        vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flag_invalid", {31'd0, flag_invalid}, 32'd0);
        check("rst_flag_ovf", {31'd0, flag_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid_after", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, r, fi, fo, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].r);
            check($sformatf("vec%0d_invalid", i), {31'd0, fi}, {31'd0, vecs[i].inv});
            check($sformatf("vec%0d_ovf", i), {31'd0, fo}, {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_latency", i), lat, 32'd5);
        end

        // Backpressure: result frozen, in_valid ignored while HOLD waits on out_ready.
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h40000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h4E000000 + 32'(i);
            b = 32'hC1200000;
            @(posedge clk);
            #1;
            check("bp_result", result, 32'h40400000);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_flags", {30'd0, flag_invalid, flag_ovf}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        do_op(32'h3F800000, 32'h3F800000, 0, r, fi, fo, lat);
        check("bp_next_result", r, 32'h40000000);
        check("bp_next_latency", lat, 32'd5);

        // Reset while the operation sits in NORM.
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h40000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", seen, 32'd0);
        do_op(32'h40400000, 32'hBF800000, 0, r, fi, fo, lat);
        check("mid_rst_next_result", r, 32'h40000000);
        check("mid_rst_next_latency", lat, 32'd5);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            ra = gen_a();
            rb = gen_b(ra);
            do_op(ra, rb, int'($urandom_range(0, 2)), r, fi, fo, lat);
            ref_add(ra, rb, r_exp, fi_exp, fo_exp);
            if (r !== r_exp || fi !== fi_exp || fo !== fo_exp || lat != 5) begin
                $display("  operands a=%h b=%h", ra, rb);
            end
            check("rand_result", r, r_exp);
            check("rand_invalid", {31'd0, fi}, {31'd0, fi_exp});
            check("rand_ovf", {31'd0, fo}, {31'd0, fo_exp});
            check("rand_latency", lat, 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
